// File: rtl/ucsbece154b_fetch_if.sv
// Instruction-memory channel of the fetch stage: valid/ready request, valid-only response.
// master = fetch stage, slave = instruction memory.
interface ucsbece154b_fetch_if;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [31:0] ImemAddr;
    logic        ImemRespValid;
    logic [31:0] ImemRespData;

    modport master (
        output ImemReqValid,
        output ImemAddr,
        input  ImemReqReady,
        input  ImemRespValid,
        input  ImemRespData
    );

    modport slave (
        input  ImemReqValid,
        input  ImemAddr,
        output ImemReqReady,
        output ImemRespValid,
        output ImemRespData
    );
endinterface

// File: rtl/ucsbece154b_fetch.sv
// Fetch stage: owns PCF, one outstanding imem request, a 1-entry fetch buffer and IF/ID.
// Optional macro FETCH_BYPASS_EN writes a WAIT-state response straight into IF/ID.
module ucsbece154b_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       StallF_i,
    input  logic                       StallD_i,
    input  logic                       FlushD_i,
    input  logic                       PCSrcE_i,
    input  logic [31:0]                PCTargetE_i,
    ucsbece154b_fetch_if.master        imem,
    output logic [31:0]                InstrD_o,
    output logic [31:0]                PCD_o,
    output logic [31:0]                PCPlus4D_o,
    output logic                       ValidD_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_e;

    state_e      state_q;
    logic [31:0] pcf_q;
    logic [31:0] reqpc_q;
    logic        fb_valid_q;
    logic [31:0] fb_instr_q;
    logic [31:0] fb_pc_q;
    logic [31:0] instrd_q;
    logic [31:0] pcd_q;
    logic [31:0] pcplus4d_q;
    logic        validd_q;

    logic consume_fb;
    logic resp_fire;
    logic bypass;
    logic req_valid;
    logic accept;

    always_comb begin
        consume_fb = fb_valid_q && !StallD_i && !FlushD_i && !PCSrcE_i;
        resp_fire  = imem.ImemRespValid && (state_q == S_WAIT || state_q == S_DISCARD);
`ifdef FETCH_BYPASS_EN
        bypass     = resp_fire && (state_q == S_WAIT) && !fb_valid_q &&
                     !StallD_i && !FlushD_i && !PCSrcE_i;
`else
        bypass     = 1'b0;
`endif
        // A bypassed response frees the channel, so the next request may go out from WAIT.
        req_valid  = !reset && !StallF_i && !PCSrcE_i && (!fb_valid_q || consume_fb) &&
                     (state_q == S_REQ || bypass);
        accept     = req_valid && imem.ImemReqReady;
    end

    assign imem.ImemReqValid = req_valid;
    assign imem.ImemAddr     = pcf_q;

    assign InstrD_o   = instrd_q;
    assign PCD_o      = pcd_q;
    assign PCPlus4D_o = pcplus4d_q;
    assign ValidD_o   = validd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pcf_q      <= RESET_PC;
            reqpc_q    <= '0;
            fb_valid_q <= 1'b0;
            fb_instr_q <= '0;
            fb_pc_q    <= '0;
            instrd_q   <= NOP_INSTR;
            pcd_q      <= '0;
            pcplus4d_q <= '0;
            validd_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (accept) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (PCSrcE_i)       state_q <= resp_fire ? S_REQ : S_DISCARD;
                    else if (resp_fire) state_q <= accept ? S_WAIT : S_REQ;
                end
                S_DISCARD: begin
                    if (resp_fire) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase

            if (accept) reqpc_q <= pcf_q;

            if (PCSrcE_i)    pcf_q <= PCTargetE_i;
            else if (accept) pcf_q <= pcf_q + 32'd4;

            // Redirect kills the buffer; a refill wins over a same-edge consume.
            if (PCSrcE_i) begin
                fb_valid_q <= 1'b0;
            end else if (state_q == S_WAIT && resp_fire && !bypass) begin
                fb_valid_q <= 1'b1;
                fb_instr_q <= imem.ImemRespData;
                fb_pc_q    <= reqpc_q;
            end else if (consume_fb) begin
                fb_valid_q <= 1'b0;
            end

            if (!StallD_i) begin
                if (consume_fb) begin
                    instrd_q   <= fb_instr_q;
                    pcd_q      <= fb_pc_q;
                    pcplus4d_q <= fb_pc_q + 32'd4;
                    validd_q   <= 1'b1;
                end else if (bypass) begin
                    instrd_q   <= imem.ImemRespData;
                    pcd_q      <= reqpc_q;
                    pcplus4d_q <= reqpc_q + 32'd4;
                    validd_q   <= 1'b1;
                end else begin
                    instrd_q   <= NOP_INSTR;
                    pcd_q      <= '0;
                    pcplus4d_q <= '0;
                    validd_q   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154b_fetch.sv
// Self-checking bench for ucsbece154b_fetch: transaction-level model with a queue-based fetch buffer.
module tb_ucsbece154b_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTarget;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    ucsbece154b_fetch_if imem();

    ucsbece154b_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .StallF_i   (StallF),
        .StallD_i   (StallD),
        .FlushD_i   (FlushD),
        .PCSrcE_i   (PCSrcE),
        .PCTargetE_i(PCTarget),
        .imem       (imem),
        .InstrD_o   (InstrD),
        .PCD_o      (PCD),
        .PCPlus4D_o (PCPlus4D),
        .ValidD_o   (ValidD)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } dec_t;

    // Model: pending request (with drop flag), FB as a queue of at most one entry, decode register.
    bit          m_known = 1'b0;
    logic [31:0] m_pc;
    bit          m_pend, m_drop;
    logic [31:0] m_pend_pc;
    dec_t        fb_q[$];
    dec_t        m_dec;

    // Memory environment
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr;
    int          lat_lo = 1, lat_hi = 1;

    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] vld_pc[$];
    int          vld_cyc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit rst, input bit sf, input bit sd, input bit fd,
                         input bit pcs, input logic [31:0] tgt, input bit rdy);
        bit          rv, consume, resp, byp, exp_req, accept;
        logic [31:0] rd;
        reset    = rst;
        StallF   = sf;
        StallD   = sd;
        FlushD   = fd;
        PCSrcE   = pcs;
        PCTarget = tgt;
        imem.ImemReqReady = rdy;
        if (mem_busy && mem_cnt == 0) begin
            rv = 1'b1;
            rd = mem_word(mem_addr);
            mem_busy = 1'b0;
        end else begin
            rv = 1'b0;
            rd = $urandom;
            if (mem_busy) mem_cnt--;
        end
        imem.ImemRespValid = rv;
        imem.ImemRespData  = rd;
        #3;

        consume = fb_q.size() != 0 && !sd && !fd && !pcs;
        resp    = m_pend && rv;
        byp     = BYP && resp && !m_drop && fb_q.size() == 0 && !sd && !fd && !pcs;
        exp_req = !rst && (!m_pend || byp) && !sf && !pcs && (fb_q.size() == 0 || consume);

        if (m_known) begin
            chk("req_valid", 32'(imem.ImemReqValid), 32'(exp_req));
            if (!rst) chk("imem_addr", imem.ImemAddr, m_pc);
            chk("instrD", InstrD, m_dec.instr);
            chk("pcD", PCD, m_dec.pc);
            chk("pcplus4D", PCPlus4D, m_dec.valid ? m_dec.pc + 32'd4 : 32'd0);
            chk("validD", 32'(ValidD), 32'(m_dec.valid));
            if (!rst && exp_req && rdy) begin
                acc_addr.push_back(m_pc);
                acc_cyc.push_back(cyc);
            end
            if (m_dec.valid) begin
                vld_pc.push_back(m_dec.pc);
                vld_cyc.push_back(cyc);
            end
        end

        if (imem.ImemReqValid === 1'b1 && rdy) begin
            mem_busy = 1'b1;
            mem_addr = imem.ImemAddr;
            mem_cnt  = $urandom_range(lat_hi, lat_lo) - 1;
        end

        @(posedge clk);
        if (rst) begin
            m_pc    = RESET_PC;
            m_pend  = 1'b0;
            m_drop  = 1'b0;
            fb_q.delete();
            m_dec   = '{instr: NOP, pc: '0, valid: 1'b0};
            m_known = 1'b1;
        end else if (m_known) begin
            accept = exp_req && rdy;
            if (!sd) begin
                if (consume)  m_dec = '{instr: fb_q[0].instr, pc: fb_q[0].pc, valid: 1'b1};
                else if (byp) m_dec = '{instr: rd, pc: m_pend_pc, valid: 1'b1};
                else          m_dec = '{instr: NOP, pc: '0, valid: 1'b0};
            end
            if (consume) void'(fb_q.pop_front());
            if (resp && !m_drop && !byp && !pcs) fb_q.push_back('{instr: rd, pc: m_pend_pc, valid: 1'b1});
            if (pcs) fb_q.delete();
            if (resp)                m_pend = 1'b0;
            else if (pcs && m_pend)  m_drop = 1'b1;
            if (accept) begin
                m_pend    = 1'b1;
                m_drop    = 1'b0;
                m_pend_pc = m_pc;
            end
            if (pcs)         m_pc = tgt;
            else if (accept) m_pc = m_pc + 32'd4;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic clear_log();
        acc_addr.delete();
        acc_cyc.delete();
        vld_pc.delete();
        vld_cyc.delete();
    endtask

    task automatic run_to_pend(input string name, input logic [31:0] addr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            idle(1);
            if (m_pend && m_pend_pc == addr) found = 1'b1;
        end
        chk(name, 32'(found), 32'd1);
    endtask

    task automatic front_acc(input string name, input logic [31:0] exp);
        chk({name, "_present"}, 32'(acc_addr.size() > 0), 32'd1);
        if (acc_addr.size() > 0) chk(name, acc_addr[0], exp);
    endtask

    task automatic front_vld(input string name, input logic [31:0] exp);
        chk({name, "_present"}, 32'(vld_pc.size() > 0), 32'd1);
        if (vld_pc.size() > 0) chk(name, vld_pc[0], exp);
    endtask

    initial begin
        int rc;
        logic [31:0] tgt;
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTarget = '0;
        imem.ImemReqReady = 1'b1; imem.ImemRespValid = 1'b0; imem.ImemRespData = '0;

        // Straight-line fetch with a 1-cycle memory
        lat_lo = 1; lat_hi = 1;
        do_reset(2);
        clear_log();
        idle(12);
        chk("p1_acc_count", 32'(acc_addr.size() >= 3), 32'd1);
        chk("p1_vld_count", 32'(vld_pc.size() >= 3), 32'd1);
        if (acc_addr.size() >= 3 && vld_pc.size() >= 3) begin
            chk("p1_addr0", acc_addr[0], 32'h0);
            chk("p1_addr1", acc_addr[1], 32'h4);
            chk("p1_addr2", acc_addr[2], 32'h8);
            chk("p1_pcd0", vld_pc[0], 32'h0);
            chk("p1_pcd1", vld_pc[1], 32'h4);
            chk("p1_pcd2", vld_pc[2], 32'h8);
            chk("p1_gap01", 32'(vld_cyc[1] - vld_cyc[0]), BYP ? 32'd1 : 32'd2);
            chk("p1_gap12", 32'(vld_cyc[2] - vld_cyc[1]), BYP ? 32'd1 : 32'd2);
        end

        // Decode stall with a full buffer, then ready held low
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        idle(4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        idle(4);

        // Redirect while 0x8 is outstanding, response arrives later and is discarded
        lat_lo = 3; lat_hi = 3;
        do_reset(1);
        run_to_pend("p3_reach", 32'h8);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        clear_log();
        idle(20);
        front_acc("p3_next_addr", 32'h100);
        front_vld("p3_next_pcd", 32'h100);

        // Redirect in the same cycle as the response for 0xC
        lat_lo = 1; lat_hi = 1;
        do_reset(1);
        run_to_pend("p4_reach", 32'hC);
        rc = cyc;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        clear_log();
        idle(10);
        front_acc("p4_next_addr", 32'h100);
        chk("p4_next_cyc_present", 32'(acc_cyc.size() > 0), 32'd1);
        if (acc_cyc.size() > 0) chk("p4_next_cyc", 32'(acc_cyc[0]), 32'(rc + 1));
        front_vld("p4_next_pcd", 32'h100);

        // Reset while waiting; the stale response lands in REQ
        lat_lo = 3; lat_hi = 3;
        do_reset(1);
        run_to_pend("p6_reach", RESET_PC);
        do_reset(1);
        clear_log();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("p6_no_valid_yet", 32'(vld_pc.size()), 32'd0);
        idle(10);
        front_acc("p6_first_addr", RESET_PC);

        // Wrap-around of PC arithmetic
        lat_lo = 1; lat_hi = 1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        clear_log();
        idle(8);
        front_acc("wrap_first", 32'hFFFF_FFFC);
        if (acc_addr.size() > 1) chk("wrap_second", acc_addr[1], 32'h0);

        // Randomized traffic
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            tgt = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cycle($urandom_range(199, 0) == 0,
                  $urandom_range(4, 0) == 0,
                  $urandom_range(3, 0) == 0,
                  $urandom_range(7, 0) == 0,
                  $urandom_range(9, 0) == 0,
                  tgt,
                  $urandom_range(3, 0) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ucsbece154b_fetch.md
Name: ucsbece154b_fetch

Overview:
Instruction-fetch stage for the ECE 154B pipelined RISC-V core. It owns PCF and the IF/ID pipeline register, and acts on the hazard and redirect controls produced by the controller (StallF, StallD, FlushD, PCSrcE). It talks to a variable-latency instruction memory over a valid/ready request channel and a valid-only response channel. Only one request is outstanding at a time, and a 1-entry fetch buffer (FB) decouples memory responses from decode stalls.

Parameters:
RESET_PC, 32'h0000_0000, PCF value after reset.
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) inserted into decode on a bubble or flush.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high.
StallF_i  input  1  hold fetch; no new request accepted.
StallD_i  input  1  hold IF/ID register.
FlushD_i  input  1  load a bubble into IF/ID.
PCSrcE_i  input  1  redirect request from execute.
PCTargetE_i  input  32  redirect target.
ImemReqValid_o  output  1  request valid.
ImemReqReady_i  input  1  memory accepts request.
ImemAddr_o  output  32  request address (= PCF).
ImemRespValid_i  input  1  response data valid.
ImemRespData_i  input  32  instruction word.
InstrD_o  output  32  decode-stage instruction.
PCD_o  output  32  decode-stage PC.
PCPlus4D_o  output  32  PCD_o + 4.
ValidD_o  output  1  1 = real instruction in decode, 0 = bubble.

Behaviour:
- Reset values: PCF=RESET_PC, state=REQ, FBValid=0, InstrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=0, ValidD_o=0. ImemReqValid_o is forced to 0 while reset=1.
- FSM states: REQ, WAIT, DISCARD.
- REQ:
  - ImemReqValid_o = !StallF_i && !PCSrcE_i && (!FBValid || consumeFB).
  - On accept (valid && ready): ReqPC <= PCF, PCF <= PCF+4, go to WAIT.
  - When not accepted, ImemAddr_o stays stable.
- WAIT:
  - ImemRespValid_i is sampled only in WAIT or DISCARD. A response in the same cycle as the accept is ignored.
  - On response: FB <= {data, ReqPC}, FBValid <= 1, go to REQ.
- DISCARD:
  - On response: drop the data and go to REQ.
- Redirect (PCSrcE_i=1) has highest priority over StallF_i and StallD_i. On redirect:
  - PCF <= PCTargetE_i and FBValid <= 0.
  - WAIT with no response this cycle goes to DISCARD.
  - WAIT with a response this cycle drops the response and goes to REQ.
  - REQ stays in REQ with no request issued this cycle.
- consumeFB = FBValid && !StallD_i && !FlushD_i && !PCSrcE_i.
- IF/ID register update, in priority order:
  - reset: load reset values.
  - StallD_i=1: hold all outputs.
  - FlushD_i=1: InstrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=0, ValidD_o=0. FB is not touched unless PCSrcE_i=1.
  - consumeFB: load FB into IF/ID, ValidD_o=1, FBValid <= 0 (unless refilled the same edge).
  - Otherwise: load a bubble as in the FlushD_i case.
- StallF_i only blocks new requests. An in-flight response is still captured into FB.
- Timing:
  - Minimum latency, request accept to ValidD_o: 2 edges with a 1-cycle memory.
  - Sustained throughput: 1 instruction per 2 cycles.
- Arithmetic: all PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
- Reset mid-transaction: state returns to REQ, so a stale response arriving after reset is ignored.

Optional Feature:
Macro FETCH_BYPASS_EN.
- Defined: in WAIT, a response with FBValid=0, StallD_i=0, FlushD_i=0 and PCSrcE_i=0 is written directly into IF/ID, bypassing FB. This gives a 1-edge latency from response to decode, and a new request may be issued in the same cycle. Sustained throughput rises to 1 instruction/cycle with a 1-cycle memory.
- Undefined: all responses pass through FB, as specified above.

Test Plan:
1. Reset, RESET_PC=0x0, ready=1, 1-cycle memory → ImemAddr_o sequence 0x0,0x4,0x8; PCD_o=0x0,0x4,0x8 with ValidD_o=1 every other cycle and bubbles in between (every cycle with FETCH_BYPASS_EN).
2. FB full, StallD_i=1 for 3 cycles → InstrD_o/PCD_o held, ImemReqValid_o=0, FB retained; on release PCD_o advances by 4.
3. Request for 0x8 outstanding, PCSrcE_i=1 with target 0x100, response 2 cycles later → response dropped (DISCARD), next ImemAddr_o=0x100, next valid PCD_o=0x100.
4. PCSrcE_i=1 in the same cycle as the response for 0xC → response dropped, request for 0x100 issued next cycle.
5. ImemReqReady_i=0 for 4 cycles → ImemReqValid_o stays 1, ImemAddr_o stable, ValidD_o=0 throughout.
6. Assert reset while in WAIT, then a stale response arrives → ignored; first request after reset is RESET_PC, ValidD_o=0 until its response.
